// File: rtl/spi_input_controller_adc.sv
// ---------------------------------------------------------------------------
// spi_input_controller_adc
//
// SPI master that reads one 16-bit word per request from the microphone ADC
// and presents the low 12 bits as an unsigned sample with a one-cycle strobe.
// Receive-side counterpart of the SPI DAC output controller.
//
// Frame: CS_n low, SCLK held high for HALF_PERIOD cycles, then 16 bit-periods
// (SCLK low HALF_PERIOD, high HALF_PERIOD), MSB first. SDATA is captured on
// the cycle SCLK rises. CS_n then stays high for at least QUIET_CYCLES.
//
// Parameters:
//   HALF_PERIOD   clock_50Mhz cycles per SCLK half-period (4..255)
//   QUIET_CYCLES  minimum CS_n-high cycles between frames
//
// Ports:
//   clock_50Mhz      in   system clock
//   reset_n          in   asynchronous active-low reset
//   input_SPI_SDATA  in   ADC serial data (asynchronous, synchronized here)
//   output_SPI_SCLK  out  SPI clock, idles high
//   output_SPI_CS_n  out  ADC chip select, active low
//   requestSample    in   level start, only looked at in IDLE
//   outputSample     out  last captured 12-bit sample (held)
//   sampleValid      out  one-cycle pulse when outputSample updates
//   isBusy           out  high in every state except IDLE
//   frameError       out  leading-zero nibble was non-zero on last frame
//
// Optional feature macro: SPI_ADC_ZERO_CHECK_EN
//   defined   -> frameError reports shift[15:12] != 0 on each sampleValid
//   undefined -> frameError tied low, no check logic
// ---------------------------------------------------------------------------
module spi_input_controller_adc #(
  parameter int HALF_PERIOD  = 25,
  parameter int QUIET_CYCLES = 50
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic        input_SPI_SDATA,
  output logic        output_SPI_SCLK,
  output logic        output_SPI_CS_n,
  input  logic        requestSample,
  output logic [11:0] outputSample,
  output logic        sampleValid,
  output logic        isBusy,
  output logic        frameError
);

  localparam int MAXC = (HALF_PERIOD > QUIET_CYCLES) ? HALF_PERIOD : QUIET_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HP_M1 = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] QC_M1 = CW'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     bitcnt_q, bitcnt_d;
  logic [15:0]    shift_q, shift_d;
  logic [11:0]    sample_q, sample_d;
  logic           sclk_q, sclk_d;
  logic           cs_n_q, cs_n_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic           req_q, req_d;
  logic           sync1_q, sync2_q;

  // Request is latched only while idle; the FSM acts on it one edge later,
  // which puts CS_n low one cycle after the sampling edge and leaves one
  // extra idle cycle between back-to-back frames.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    sclk_d   = 1'b1;
    valid_d  = 1'b0;
    req_d    = (state_q == IDLE) && requestSample;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        if (req_q) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == HP_M1) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        sclk_d = sclk_q;
        if (cnt_q == HP_M1) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // rising SCLK: capture one bit
            sclk_d   = 1'b1;
            shift_d  = {shift_q[14:0], sync2_q};
            bitcnt_d = bitcnt_q + 1'b1;
          end else if (bitcnt_q == 5'd16) begin
            // end of high time after the 16th rise
            state_d  = QUIET;
            sclk_d   = 1'b1;
            valid_d  = 1'b1;
            sample_d = shift_q[11:0];
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      QUIET: begin
        bitcnt_d = '0;
        if (cnt_q == QC_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      sync1_q  <= input_SPI_SDATA;
      sync2_q  <= sync1_q;
    end
  end

`ifdef SPI_ADC_ZERO_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (valid_d) err_d = (shift_q[15:12] != 4'h0);
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign frameError = err_q;
`else
  assign frameError = 1'b0;
`endif

  assign output_SPI_SCLK = sclk_q;
  assign output_SPI_CS_n = cs_n_q;
  assign outputSample    = sample_q;
  assign sampleValid     = valid_q;
  assign isBusy          = busy_q;

endmodule
